// File: rtl/edf_irq_ctrl.sv
// edf_irq_ctrl: core-side sequencer for the EDF interrupt controller.
// Presents the arbitration winner to the core, runs the claim handshake,
// returns a one-cycle ack to the controller and keeps a nesting stack of
// in-service interrupts with per-entry deadline-miss tracking.
// Optional feature macro: EDF_CTRL_MISS_CNT_EN (saturating 16-bit miss counter
// on miss_cnt_o; when undefined the output is tied to zero).
module edf_irq_ctrl #(
  parameter int unsigned NrIrqs  = 4,
  parameter int unsigned DlWidth = 24,
  parameter int unsigned DlClip  = 0,
  parameter int unsigned MaxNest = 4,
  localparam int unsigned IdWidth = $clog2(NrIrqs),
  localparam int unsigned NestW   = $clog2(MaxNest + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               irq_valid_i,
  input  logic [IdWidth-1:0] irq_id_i,
  input  logic [DlWidth-1:0] irq_dl_i,
  output logic               irq_ack_o,
  output logic [IdWidth-1:0] irq_ack_id_o,
  input  logic [63:0]        mtime_i,
  output logic               core_irq_o,
  output logic [IdWidth-1:0] core_irq_id_o,
  input  logic               core_claim_i,
  input  logic               core_done_i,
  output logic [NestW-1:0]   nest_o,
  output logic               miss_o,
  output logic [15:0]        miss_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACK
  } state_e;

  // a is before b when the wrapped difference is negative (half-range window)
  function automatic logic dl_before(input logic [DlWidth-1:0] a, input logic [DlWidth-1:0] b);
    logic [DlWidth-1:0] diff;
    diff = a - b;
    return diff[DlWidth-1];
  endfunction

  state_e             state_q, state_d;
  logic [IdWidth-1:0] lat_id_q, lat_id_d;
  logic [DlWidth-1:0] lat_dl_q, lat_dl_d;
  logic               core_irq_q, core_irq_d;
  logic [IdWidth-1:0] core_irq_id_q, core_irq_id_d;
  logic               ack_q, ack_d;
  logic [IdWidth-1:0] ack_id_q, ack_id_d;
  logic               miss_q, miss_d;
  logic [NestW-1:0]   depth_q, depth_d;

  logic [IdWidth-1:0] stk_id_q   [MaxNest];
  logic [IdWidth-1:0] stk_id_d   [MaxNest];
  logic [DlWidth-1:0] stk_dl_q   [MaxNest];
  logic [DlWidth-1:0] stk_dl_d   [MaxNest];
  logic               stk_miss_q [MaxNest];
  logic               stk_miss_d [MaxNest];

  logic [63:0]        mtime_sh;
  logic [DlWidth-1:0] now;
  logic               unused_mtime;
  logic [DlWidth-1:0] top_dl;
  logic               top_miss;
  logic               eligible;
  logic               push;
  logic               pop;
  logic               miss_det;
  logic [NestW-1:0]   base;

  assign mtime_sh     = mtime_i >> DlClip;
  assign now          = mtime_sh[DlWidth-1:0];
  assign unused_mtime = ^mtime_sh[63:DlWidth];

  // Select the registered top-of-stack entry (depth-1) without a wide array index
  always_comb begin
    top_dl   = '0;
    top_miss = 1'b0;
    for (int unsigned i = 0; i < MaxNest; i++) begin
      if (i + 1 == 32'(depth_q)) begin
        top_dl   = stk_dl_q[i];
        top_miss = stk_miss_q[i];
      end
    end
  end

  // Next-state logic: handshake FSM, stack push/pop and miss detection
  always_comb begin
    state_d       = state_q;
    lat_id_d      = lat_id_q;
    lat_dl_d      = lat_dl_q;
    core_irq_d    = 1'b0;
    core_irq_id_d = '0;
    ack_d         = 1'b0;
    ack_id_d      = '0;
    depth_d       = depth_q;
    stk_id_d      = stk_id_q;
    stk_dl_d      = stk_dl_q;
    stk_miss_d    = stk_miss_q;
    push          = 1'b0;

    eligible = irq_valid_i && (32'(depth_q) < MaxNest) &&
               ((depth_q == '0) || dl_before(irq_dl_i, top_dl));

    unique case (state_q)
      IDLE: begin
        if (eligible) begin
          state_d       = REQ;
          lat_id_d      = irq_id_i;
          lat_dl_d      = irq_dl_i;
          core_irq_d    = 1'b1;
          core_irq_id_d = irq_id_i;
        end
      end
      REQ: begin
        // A claim is honoured against the eligibility that raised the request
        if (core_claim_i) begin
          push     = 1'b1;
          state_d  = ACK;
          ack_d    = 1'b1;
          ack_id_d = lat_id_q;
        end else if (eligible) begin
          lat_id_d      = irq_id_i;
          lat_dl_d      = irq_dl_i;
          core_irq_d    = 1'b1;
          core_irq_id_d = irq_id_i;
        end else begin
          state_d = IDLE;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    miss_det = (depth_q != '0) && !top_miss && !dl_before(now, top_dl);
    miss_d   = miss_det;
    if (miss_det) begin
      for (int unsigned i = 0; i < MaxNest; i++) begin
        if (i + 1 == 32'(depth_q)) stk_miss_d[i] = 1'b1;
      end
    end

    // Pop is applied before push so a same-cycle pair replaces the top in place
    pop  = core_done_i && (depth_q != '0);
    base = pop ? depth_q - NestW'(1) : depth_q;
    if (push) begin
      for (int unsigned i = 0; i < MaxNest; i++) begin
        if (i == 32'(base)) begin
          stk_id_d[i]   = lat_id_q;
          stk_dl_d[i]   = lat_dl_q;
          stk_miss_d[i] = 1'b0;
        end
      end
      depth_d = base + NestW'(1);
    end else begin
      depth_d = base;
    end
  end

  // State, stack and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      lat_id_q      <= '0;
      lat_dl_q      <= '0;
      core_irq_q    <= 1'b0;
      core_irq_id_q <= '0;
      ack_q         <= 1'b0;
      ack_id_q      <= '0;
      miss_q        <= 1'b0;
      depth_q       <= '0;
      for (int unsigned i = 0; i < MaxNest; i++) begin
        stk_id_q[i]   <= '0;
        stk_dl_q[i]   <= '0;
        stk_miss_q[i] <= 1'b0;
      end
    end else begin
      state_q       <= state_d;
      lat_id_q      <= lat_id_d;
      lat_dl_q      <= lat_dl_d;
      core_irq_q    <= core_irq_d;
      core_irq_id_q <= core_irq_id_d;
      ack_q         <= ack_d;
      ack_id_q      <= ack_id_d;
      miss_q        <= miss_d;
      depth_q       <= depth_d;
      stk_id_q      <= stk_id_d;
      stk_dl_q      <= stk_dl_d;
      stk_miss_q    <= stk_miss_d;
    end
  end

  assign core_irq_o    = core_irq_q;
  assign core_irq_id_o = core_irq_id_q;
  assign irq_ack_o     = ack_q;
  assign irq_ack_id_o  = ack_id_q;
  assign nest_o        = depth_q;
  assign miss_o        = miss_q;

`ifdef EDF_CTRL_MISS_CNT_EN
  logic [15:0] miss_cnt_q, miss_cnt_d;

  // Saturating count of miss_o pulses
  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (miss_q && (miss_cnt_q != 16'hFFFF)) miss_cnt_d = miss_cnt_q + 16'd1;
  end

  // Miss counter register, cleared only by reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) miss_cnt_q <= '0;
    else       miss_cnt_q <= miss_cnt_d;
  end

  assign miss_cnt_o = miss_cnt_q;
`else
  assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_edf_irq_ctrl.sv
// Self-checking bench for edf_irq_ctrl: claimed ids go into a scoreboard
// queue and are compared against the ack pulses the DUT returns.
module tb_edf_irq_ctrl;
  localparam int unsigned IdWidth = 2;
  localparam int unsigned DlWidth = 24;
  localparam int unsigned NestW   = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               irq_valid_i;
  logic [IdWidth-1:0] irq_id_i;
  logic [DlWidth-1:0] irq_dl_i;
  logic               irq_ack_o;
  logic [IdWidth-1:0] irq_ack_id_o;
  logic [63:0]        mtime_i;
  logic               core_irq_o;
  logic [IdWidth-1:0] core_irq_id_o;
  logic               core_claim_i;
  logic               core_done_i;
  logic [NestW-1:0]   nest_o;
  logic               miss_o;
  logic [15:0]        miss_cnt_o;

  edf_irq_ctrl #(
    .NrIrqs (4),
    .DlWidth(24),
    .DlClip (0),
    .MaxNest(4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .irq_valid_i  (irq_valid_i),
    .irq_id_i     (irq_id_i),
    .irq_dl_i     (irq_dl_i),
    .irq_ack_o    (irq_ack_o),
    .irq_ack_id_o (irq_ack_id_o),
    .mtime_i      (mtime_i),
    .core_irq_o   (core_irq_o),
    .core_irq_id_o(core_irq_id_o),
    .core_claim_i (core_claim_i),
    .core_done_i  (core_done_i),
    .nest_o       (nest_o),
    .miss_o       (miss_o),
    .miss_cnt_o   (miss_cnt_o)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned ack_seen  = 0;
  int unsigned miss_seen = 0;
  logic [IdWidth-1:0] exp_ack_q[$];

`ifdef EDF_CTRL_MISS_CNT_EN
  localparam logic [15:0] ExpMissCnt = 16'd1;
`else
  localparam logic [15:0] ExpMissCnt = 16'd0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ack monitor: every ack must match the oldest outstanding claim
  always @(negedge clk) begin
    if (rst === 1'b0 && irq_ack_o === 1'b1) begin
      ack_seen++;
      if (exp_ack_q.size() == 0) check("ack_unexpected", 32'd1, 32'd0);
      else check("ack_id", 32'(irq_ack_id_o), 32'(exp_ack_q.pop_front()));
    end
    if (rst === 1'b0 && miss_o === 1'b1) miss_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    irq_valid_i  = 1'b0;
    irq_id_i     = '0;
    irq_dl_i     = '0;
    mtime_i      = '0;
    core_claim_i = 1'b0;
    core_done_i  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_req(output bit ok);
    int unsigned n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 20) begin
      if (core_irq_o === 1'b1) ok = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    if (!ok) check("req_timeout", 32'd0, 32'd1);
  endtask

  // Present a winner, wait for the request, claim after claim_dly cycles
  task automatic serve(input logic [IdWidth-1:0] id, input logic [DlWidth-1:0] dl,
                       input int unsigned claim_dly);
    bit ok;
    irq_valid_i = 1'b1;
    irq_id_i    = id;
    irq_dl_i    = dl;
    wait_req(ok);
    if (ok) begin
      check("req_id", 32'(core_irq_id_o), 32'(id));
      repeat (claim_dly) tick();
      check("req_hold", 32'(core_irq_o), 32'd1);
      core_claim_i = 1'b1;
      exp_ack_q.push_back(id);
      tick();
      core_claim_i = 1'b0;
      irq_valid_i  = 1'b0;
      check("ack_pulse", 32'(irq_ack_o), 32'd1);
      check("irq_low_in_ack", 32'(core_irq_o), 32'd0);
      tick();
      check("ack_one_cycle", 32'(irq_ack_o), 32'd0);
    end else begin
      irq_valid_i = 1'b0;
    end
  endtask

  task automatic pop_one();
    core_done_i = 1'b1;
    tick();
    core_done_i = 1'b0;
  endtask

  initial begin
    bit ok;
    bit any_req;
    int unsigned acks0;
    int unsigned miss0;

    // Reset values
    do_reset();
    check("rst_core_irq", 32'(core_irq_o), 32'd0);
    check("rst_ack", 32'(irq_ack_o), 32'd0);
    check("rst_nest", 32'(nest_o), 32'd0);
    check("rst_miss", 32'(miss_o), 32'd0);
    check("rst_miss_cnt", 32'(miss_cnt_o), 32'd0);

    // Single interrupt, claim two cycles after the request
    serve(2'd2, 24'd100, 2);
    check("single_nest", 32'(nest_o), 32'd1);
    repeat (3) tick();
    check("single_no_rereq", 32'(core_irq_o), 32'd0);

    // Preemption only on a strictly earlier deadline
    do_reset();
    serve(2'd1, 24'd500, 1);
    check("pre_nest1", 32'(nest_o), 32'd1);
    serve(2'd3, 24'd300, 1);
    check("pre_nest2", 32'(nest_o), 32'd2);
    irq_valid_i = 1'b1;
    irq_id_i    = 2'd0;
    irq_dl_i    = 24'd600;
    any_req     = 1'b0;
    repeat (6) begin
      tick();
      if (core_irq_o !== 1'b0) any_req = 1'b1;
    end
    check("pre_later_no_req", 32'(any_req), 32'd0);
    irq_valid_i = 1'b0;
    pop_one();
    check("pre_pop1", 32'(nest_o), 32'd1);
    pop_one();
    check("pre_pop2", 32'(nest_o), 32'd0);
    pop_one();
    check("pop_at_zero", 32'(nest_o), 32'd0);

    // Wrap-safe ordering: 0xFFFFF0 precedes 0x000010
    do_reset();
    serve(2'd0, 24'h000010, 0);
    mtime_i     = 64'h0000_0000_00FF_FF00;
    irq_valid_i = 1'b1;
    irq_id_i    = 2'd1;
    irq_dl_i    = 24'hFFFFF0;
    wait_req(ok);
    if (ok) check("wrap_req_id", 32'(core_irq_id_o), 32'd1);
    irq_valid_i = 1'b0;
    tick();
    check("wrap_retract", 32'(core_irq_o), 32'd0);
    check("wrap_nest", 32'(nest_o), 32'd1);

    // Retract before claim: no ack, stack untouched
    do_reset();
    acks0       = ack_seen;
    irq_valid_i = 1'b1;
    irq_id_i    = 2'd1;
    irq_dl_i    = 24'd300;
    wait_req(ok);
    irq_valid_i = 1'b0;
    tick();
    check("retract_irq_low", 32'(core_irq_o), 32'd0);
    repeat (3) tick();
    check("retract_nest", 32'(nest_o), 32'd0);
    check("retract_no_ack", ack_seen, acks0);

    // Asynchronous reset while requesting
    irq_valid_i = 1'b1;
    irq_id_i    = 2'd2;
    irq_dl_i    = 24'd77;
    wait_req(ok);
    irq_valid_i = 1'b0;
    rst         = 1'b1;
    #1;
    check("async_rst_irq", 32'(core_irq_o), 32'd0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("async_rst_no_ack", ack_seen, acks0);

    // Full stack blocks requests until a pop frees a slot
    do_reset();
    serve(2'd0, 24'd400, 0);
    serve(2'd1, 24'd300, 0);
    serve(2'd2, 24'd200, 0);
    serve(2'd3, 24'd100, 0);
    check("full_nest4", 32'(nest_o), 32'd4);
    irq_valid_i = 1'b1;
    irq_id_i    = 2'd0;
    irq_dl_i    = 24'd50;
    any_req     = 1'b0;
    repeat (6) begin
      tick();
      if (core_irq_o !== 1'b0) any_req = 1'b1;
    end
    check("full_no_req", 32'(any_req), 32'd0);
    pop_one();
    check("full_pop_nest3", 32'(nest_o), 32'd3);
    serve(2'd0, 24'd50, 1);
    check("full_refill_nest4", 32'(nest_o), 32'd4);

    // Deadline miss: exactly one pulse per entry
    do_reset();
    serve(2'd2, 24'd50, 0);
    miss0   = miss_seen;
    mtime_i = 64'd49;
    repeat (4) tick();
    check("miss_before_dl", miss_seen - miss0, 32'd0);
    mtime_i = 64'd50;
    repeat (4) tick();
    check("miss_at_dl", miss_seen - miss0, 32'd1);
    mtime_i = 64'd51;
    repeat (4) tick();
    check("miss_once", miss_seen - miss0, 32'd1);
    check("miss_cnt", 32'(miss_cnt_o), 32'(ExpMissCnt));

    check("sb_empty", exp_ack_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
